// File: rtl/egress_arbiter.sv
// Egress arbiter: a round-robin grant among NUM_PORTS inputs that target PORT_ID, feeding a FIFO_DEPTH-entry output queue.
// Optional accepted-packet counter on pkt_count, enabled by defining EGRESS_ARBITER_STATS_EN.
module egress_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PORT_ID    = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [4*NUM_PORTS-1:0]          req_source,
    input  logic [4*NUM_PORTS-1:0]          req_target,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0] req_data,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic                            out_valid,
    output logic [3:0]                      out_source,
    output logic [3:0]                      out_target,
    output logic [DATA_WIDTH-1:0]           out_data,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [15:0]                     pkt_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [RW-1:0]         r_rr_ptr;
    logic [3:0]            r_mem_src  [FIFO_DEPTH];
    logic [3:0]            r_mem_tgt  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];

    logic [NUM_PORTS-1:0]  w_elig;
    logic [NUM_PORTS-1:0]  w_grant;
    logic                  w_any;
    logic [RW-1:0]         w_win;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_elig[i] = req_valid[i] & req_target[4*i+PORT_ID];
        end
    end

    // Search starts at r_rr_ptr and wraps; first eligible input wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_any   = 1'b0;
        w_win   = '0;
        w_grant = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!w_any && w_elig[idx]) begin
                w_any = 1'b1;
                w_win = RW'(idx);
            end
        end
        if (w_any) w_grant[w_win] = 1'b1;
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign req_ready = (w_any && !w_full && !rst_n) ? w_grant : '0;
    assign w_push    = |(req_valid & req_ready);
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) r_rr_ptr <= (w_win == RW'(NUM_PORTS-1)) ? '0 : w_win + RW'(1);
        end
    end

    // Queue storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_src[r_wr_ptr]  <= req_source[4*int'(w_win) +: 4];
            r_mem_tgt[r_wr_ptr]  <= req_target[4*int'(w_win) +: 4];
            r_mem_data[r_wr_ptr] <= req_data[DATA_WIDTH*int'(w_win) +: DATA_WIDTH];
        end
    end

    assign out_source = out_valid ? r_mem_src[r_rd_ptr]  : '0;
    assign out_target = out_valid ? r_mem_tgt[r_rd_ptr]  : '0;
    assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign fifo_count = r_count;

`ifdef EGRESS_ARBITER_STATS_EN
    logic [15:0] r_pkt_cnt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pkt_cnt <= '0;
        end else if (w_push && r_pkt_cnt != 16'hFFFF) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign pkt_count = r_pkt_cnt;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// Directed bench for egress_arbiter (PORT_ID=3, 4 inputs, 4-entry queue).
module tb_egress_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_source;
    logic [15:0] req_target;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_source;
    logic [3:0]  out_target;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic [15:0] pkt_count;

    int n_chk  = 0;
    int n_pass = 0;

    egress_arbiter #(
        .NUM_PORTS(4), .DATA_WIDTH(8), .FIFO_DEPTH(4), .PORT_ID(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_source(req_source), .req_target(req_target),
        .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_source(out_source), .out_target(out_target),
        .out_data(out_data), .out_ready(out_ready),
        .fifo_count(fifo_count), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_pkt(input string tag, input logic [15:0] exp);
`ifdef EGRESS_ARBITER_STATS_EN
        chk(tag, 32'(pkt_count), 32'(exp));
`else
        chk(tag, 32'(pkt_count), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
        req_valid[i]      = 1'b1;
        req_source[4*i+:4] = s;
        req_target[4*i+:4] = t;
        req_data[8*i+:8]   = d;
    endtask

    task automatic clr_req();
        req_valid  = '0;
        req_source = '0;
        req_target = '0;
        req_data   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d);
        chk(tag, 32'(out_data), 32'(d));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        out_ready = 1'b0;
        clr_req();
        // Eligible request held during reset must not be granted.
        set_req(0, 4'b0001, 4'b1000, 8'h99);
        tick();
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk_pkt("rst_pkt", 16'd0);
        clr_req();
        tick();
        rst_n = 1'b0;
        tick();

        // Single request
        set_req(0, 4'b0001, 4'b1000, 8'hAB);
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_nolat", 32'(out_valid), 32'h0);
        tick();
        clr_req();
        #1;
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_src", 32'(out_source), 32'h1);
        chk("single_tgt", 32'(out_target), 32'h8);
        chk("single_data", 32'(out_data), 32'hAB);
        chk("single_count", 32'(fifo_count), 32'h1);
        chk_pkt("single_pkt", 16'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_drain", 32'(fifo_count), 32'h0);

        // Filtering
        set_req(1, 4'b0010, 4'b0101, 8'h55);
        #1;
        chk("filt_ready", 32'(req_ready), 32'h0);
        tick();
        chk("filt_count", 32'(fifo_count), 32'h0);
        clr_req();

        // Empty pop must not underflow
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_pop_count", 32'(fifo_count), 32'h0);
        chk("empty_pop_valid", 32'(out_valid), 32'h0);

        // Contention from reset
        set_req(0, 4'b0001, 4'b1000, 8'h11);
        set_req(1, 4'b0010, 4'b1000, 8'h22);
        do_reset();
        #1;
        chk("cont_g0", 32'(req_ready), 32'h1);
        tick();
        chk("cont_g1", 32'(req_ready), 32'h2);
        tick();
        // rr_ptr is now 2: input 2 beats input 0
        req_valid[1] = 1'b0;
        set_req(2, 4'b0100, 4'b1000, 8'h33);
        #1;
        chk("cont_rr2", 32'(req_ready), 32'h4);
        tick();
        clr_req();
        chk("cont_count", 32'(fifo_count), 32'h3);
        chk_pkt("cont_pkt", 16'd3);
        pop_check("cont_o0", 8'h11);
        pop_check("cont_o1", 8'h22);
        pop_check("cont_o2", 8'h33);
        chk("cont_empty", 32'(fifo_count), 32'h0);

        // Full queue
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(2, 4'b0100, 4'b1000, 8'(8'hA0 + k));
            #1;
            chk("full_acc", 32'(req_ready), 32'h4);
            tick();
        end
        set_req(2, 4'b0100, 4'b1000, 8'hA4);
        #1;
        chk("full_count", 32'(fifo_count), 32'h4);
        chk("full_held", 32'(req_ready), 32'h0);
        tick();
        chk("full_stay", 32'(fifo_count), 32'h4);
        out_ready = 1'b1;
        #1;
        chk("full_pop_nogrant", 32'(req_ready), 32'h0);
        chk("full_head", 32'(out_data), 32'hA0);
        tick();
        out_ready = 1'b0;
        chk("full_after_pop", 32'(fifo_count), 32'h3);
        chk("full_5th_ready", 32'(req_ready), 32'h4);
        tick();
        clr_req();
        chk("full_refill", 32'(fifo_count), 32'h4);
        chk_pkt("full_pkt", 16'd5);
        pop_check("full_o1", 8'hA1);
        pop_check("full_o2", 8'hA2);
        pop_check("full_o3", 8'hA3);
        pop_check("full_o4", 8'hA4);
        chk("full_empty", 32'(fifo_count), 32'h0);

        // Simultaneous push and pop
        do_reset();
        set_req(0, 4'b0001, 4'b1000, 8'h51);
        tick();
        set_req(0, 4'b0001, 4'b1000, 8'h52);
        tick();
        chk("pp_pre", 32'(fifo_count), 32'h2);
        set_req(0, 4'b0001, 4'b1000, 8'h53);
        out_ready = 1'b1;
        #1;
        chk("pp_head", 32'(out_data), 32'h51);
        tick();
        clr_req();
        out_ready = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'h2);
        pop_check("pp_o1", 8'h52);
        pop_check("pp_o2", 8'h53);
        chk("pp_empty", 32'(fifo_count), 32'h0);

        // Reset mid-operation
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_req(0, 4'b0001, 4'b1000, 8'(8'h61 + k));
            tick();
        end
        clr_req();
        chk("mid_pre", 32'(fifo_count), 32'h3);
        chk_pkt("mid_pkt_pre", 16'd3);
        rst_n = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_count", 32'(fifo_count), 32'h0);
        chk("mid_data", 32'(out_data), 32'h0);
        chk_pkt("mid_pkt", 16'd0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_nostale", 32'(out_valid), 32'h0);
        chk("mid_count2", 32'(fifo_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/egress_arbiter.md
EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of switch input ports competing for this output.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two, at least 2: output queue entries.
REQ-004 SHALL have parameter PORT_ID, default 0: index of the output port this instance serves.
REQ-005 SHALL have clk  in  1: clock; all state on rising edge.
REQ-006 SHALL have rst_n  in  1: reset, asynchronous, active-high; clock clk.
REQ-007 SHALL have req_valid  in  NUM_PORTS: per-input request valid.
REQ-008 SHALL have req_source  in  4*NUM_PORTS: per-input source one-hot; slice i = bits [4i+3:4i].
REQ-009 SHALL have req_target  in  4*NUM_PORTS: per-input target mask; sliced like req_source.
REQ-010 SHALL have req_data  in  DATA_WIDTH*NUM_PORTS: per-input payload.
REQ-011 SHALL have req_ready  out  NUM_PORTS: one-hot grant, combinational; a request is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-012 SHALL have out_valid, out_source[3:0], out_target[3:0] and out_data[DATA_WIDTH-1:0]  out: FIFO head packet.
REQ-013 SHALL have out_ready  in  1: consumer accepts the head when out_valid and out_ready are both high.
REQ-014 SHALL have fifo_count  out  $clog2(FIFO_DEPTH)+1: current occupancy.
REQ-015 SHALL have pkt_count  out  16: accepted-packet statistic (see Configuration).

Function
REQ-016 SHALL treat input i as eligible only when req_valid[i]=1 and req_target slice i has bit PORT_ID set; ineligible inputs never get req_ready.
REQ-017 SHALL assert at most one req_ready bit per cycle, and only when fifo_count < FIFO_DEPTH.
REQ-018 SHALL arbitrate round-robin: search starts at rr_ptr and wraps NUM_PORTS-1 to 0; the first eligible input wins.
REQ-019 SHALL set rr_ptr to (winner+1) mod NUM_PORTS on each accepted request, and hold rr_ptr otherwise.
REQ-020 SHALL write the accepted source, target and data unchanged into the FIFO tail at the accepting edge.
REQ-021 SHALL present an accepted packet on out_* in the cycle after acceptance when the FIFO was empty (latency 1, no combinational bypass).
REQ-022 SHALL drive out_valid = (fifo_count != 0); out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on a simultaneous push and pop, perform both and leave fifo_count unchanged.
REQ-024 SHALL, when full, grant nothing even if out_ready=1 in the same cycle; space frees on the following cycle.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH, and never overflow or underflow.
REQ-026 SHALL ignore out_ready while out_valid=0.

Reset
REQ-027 SHALL, while rst_n=1, asynchronously clear the FIFO pointers, fifo_count, rr_ptr and pkt_count to 0.
REQ-028 SHALL hold out_valid=0, out_source/out_target/out_data=0 and req_ready=0 while in reset.
REQ-029 SHALL discard all queued packets when reset is asserted mid-operation; no stale packet appears after release.
REQ-030 SHALL make its first grant possible in the first cycle after rst_n falls, with rr_ptr=0.

Configuration
REQ-031 SHALL use macro EGRESS_ARBITER_STATS_EN.
REQ-032 SHALL, with the macro defined, increment pkt_count on each accepted request and saturate it at 16'hFFFF.
REQ-033 SHALL, without the macro, tie pkt_count to 0 and include no counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover single request: PORT_ID=3, input 0 sends source=0001, target=1000, data=AB -> req_ready[0] high same cycle; out_valid next cycle with 0001/1000/AB.
REQ-035 SHALL cover filtering: input 1 sends target=0101 to a PORT_ID=3 instance -> req_ready stays 0 and fifo_count stays 0.
REQ-036 SHALL cover contention: inputs 0 and 1 both send target=1000 (data 11 and 22) continuously from reset -> grant 0 then 1; output order 11, 22; rr_ptr=2.
REQ-037 SHALL cover full queue: out_ready=0, 5 requests from input 2 -> 4 accepted, fifo_count=4, 5th held with req_ready=0; one pop with out_ready=1 -> 5th accepted the next cycle.
REQ-038 SHALL cover simultaneous push/pop: fifo_count=2, one push and one pop in the same cycle -> fifo_count stays 2 and FIFO order is preserved.
REQ-039 SHALL cover reset mid-operation: rst_n=1 with fifo_count=3 -> out_valid=0 and fifo_count=0 immediately; with EGRESS_ARBITER_STATS_EN defined, pkt_count=0.
